// File: rtl/spsram_ctrl_sm.sv
// SRAM-request backend for two ganged SB_SPRAM256KA primitives (16K x 32).
// Handles byte-to-nibble mask conversion, read capture, completion pulses and standby sequencing.
module spsram_ctrl_sm #(
   parameter int unsigned IDLE_CYCLES = 64,
   parameter int unsigned WAKE_CYCLES = 3
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [13:0] sram_addr,
   input  logic        sram_we,
   input  logic        sram_re,
   input  logic [3:0]  sram_maskwe,
   input  logic [31:0] sram_din,
   output logic [31:0] sram_dout,
   output logic        sram_write_done,
   output logic        sram_read_valid,
   output logic        sram_busy,
   output logic [13:0] spram_addr,
   output logic [15:0] spram_din_lo,
   output logic [15:0] spram_din_hi,
   output logic [3:0]  spram_mask_lo,
   output logic [3:0]  spram_mask_hi,
   output logic        spram_wren,
   output logic        spram_cs,
   output logic        spram_standby,
   input  logic [15:0] spram_dout_lo,
   input  logic [15:0] spram_dout_hi
);

   // state   | meaning
   // S_IDLE  | awake, waiting for a request, counting idle cycles
   // S_SLEEP | primitives in standby, waiting for a request
   // S_WAKE  | standby released, waiting WAKE_CYCLES before access
   // S_ACCESS| one-cycle primitive access from latched request
   // S_RDCAP | primitive read data valid, captured at end of cycle
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SLEEP  = 3'd1,
      S_WAKE   = 3'd2,
      S_ACCESS = 3'd3,
      S_RDCAP  = 3'd4
   } state_t;

   localparam int unsigned CW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
   localparam int unsigned WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
   localparam logic [CW-1:0] IDLE_TC = CW'(IDLE_CYCLES);
   localparam logic [WW-1:0] WAKE_LD = WW'(WAKE_CYCLES - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_idle_cnt;
   logic [CW-1:0] w_idle_nxt;
   logic [CW-1:0] w_idle_inc;
   logic [WW-1:0] r_wake_cnt;
   logic [WW-1:0] w_wake_nxt;
   logic          r_op_wr;
   logic [13:0]   r_addr;
   logic [31:0]   r_din;
   logic [3:0]    r_mask;
   logic          r_cs;
   logic          r_wren;
   logic          r_standby;
   logic          r_write_done;
   logic          r_read_valid;
   logic [31:0]   r_dout;
   logic          w_req;
   logic          w_acc_nxt;
   logic          w_acc_wr;
   logic [3:0]    w_acc_mask;

   assign w_req      = (sram_we | sram_re) & ((r_state == S_IDLE) | (r_state == S_SLEEP));
   assign w_idle_inc = (r_idle_cnt == {CW{1'b1}}) ? r_idle_cnt : r_idle_cnt + CW'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_idle_nxt  = r_idle_cnt;
      w_wake_nxt  = r_wake_cnt;
      w_acc_nxt   = 1'b0;
      w_acc_wr    = r_op_wr;
      w_acc_mask  = r_mask;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               w_state_nxt = S_ACCESS;
               w_idle_nxt  = '0;
               w_acc_nxt   = 1'b1;
               w_acc_wr    = sram_we;
               w_acc_mask  = sram_maskwe;
            end else begin
               w_idle_nxt = w_idle_inc;
               if ((IDLE_CYCLES != 0) && (w_idle_inc == IDLE_TC))
                  w_state_nxt = S_SLEEP;
            end
         end
         S_SLEEP: begin
            if (w_req) begin
               w_state_nxt = S_WAKE;
               w_wake_nxt  = WAKE_LD;
               w_idle_nxt  = '0;
            end
         end
         S_WAKE: begin
            if (r_wake_cnt == '0) begin
               w_state_nxt = S_ACCESS;
               w_acc_nxt   = 1'b1;
            end else begin
               w_wake_nxt = r_wake_cnt - WW'(1);
            end
         end
         S_ACCESS: w_state_nxt = r_op_wr ? S_IDLE : S_RDCAP;
         S_RDCAP:  w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state      <= S_IDLE;
         r_idle_cnt   <= '0;
         r_wake_cnt   <= '0;
         r_op_wr      <= 1'b0;
         r_addr       <= '0;
         r_din        <= '0;
         r_mask       <= '0;
         r_cs         <= 1'b0;
         r_wren       <= 1'b0;
         r_standby    <= 1'b0;
         r_write_done <= 1'b0;
         r_read_valid <= 1'b0;
         r_dout       <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_idle_cnt <= w_idle_nxt;
         r_wake_cnt <= w_wake_nxt;
         if (w_req) begin
            r_op_wr <= sram_we;
            r_addr  <= sram_addr;
            r_din   <= sram_din;
            r_mask  <= sram_maskwe;
         end
         // An all-zero write mask completes without touching the array.
         r_cs         <= w_acc_nxt & (~w_acc_wr | (w_acc_mask != 4'b0000));
         r_wren       <= w_acc_nxt & w_acc_wr;
         r_standby    <= (w_state_nxt == S_SLEEP);
         r_write_done <= (r_state == S_ACCESS) & r_op_wr;
         r_read_valid <= (r_state == S_RDCAP);
         if (r_state == S_RDCAP)
            r_dout <= {spram_dout_hi, spram_dout_lo};
      end
   end

   assign sram_dout       = r_dout;
   assign sram_write_done = r_write_done;
   assign sram_read_valid = r_read_valid;
   assign sram_busy       = (r_state != S_IDLE) && (r_state != S_SLEEP);
   assign spram_addr      = r_addr;
   assign spram_din_lo    = r_din[15:0];
   assign spram_din_hi    = r_din[31:16];
   assign spram_mask_lo   = {r_mask[1], r_mask[1], r_mask[0], r_mask[0]};
   assign spram_mask_hi   = {r_mask[3], r_mask[3], r_mask[2], r_mask[2]};
   assign spram_wren      = r_wren;
   assign spram_cs        = r_cs;
   assign spram_standby   = r_standby;

endmodule
